// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch-PC generation, a bounded number of
// outstanding imem requests, and an in-order {pc, instr, fault} queue for decode.
// A redirect flushes the queue and marks every in-flight response for discard.
module instr_prefetch_queue #(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     DEPTH        = 4,
   parameter int unsigned     MAX_OUTST    = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic            out_fault
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned OW  = $clog2(MAX_OUTST + 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   // architectural state
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [OW-1:0]   inflight_q, inflight_d;
   logic [OW-1:0]   drop_q, drop_d;
   logic            halted_q, halted_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   // queue storage
   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];
   logic            fault_mem_q [DEPTH];

   // registered head of queue
   logic            out_valid_q, out_valid_d;
   logic [31:0]     out_instr_q, out_instr_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic            out_fault_q, out_fault_d;

   // handshake decode
   logic [31:0]     used_s;
   logic            req_valid_s;
   logic            req_fire_s;
   logic            push_s;
   logic            pop_s;
   logic [31:0]     push_instr_s;
   logic [XLEN-1:0] redirect_tgt_s;

   // Decode request credit, response push and decoder pop for this cycle.
   always_comb begin
      // slots already promised: queued entries plus live (non-discarded) responses
      used_s         = 32'(count_q) + 32'(inflight_q) - 32'(drop_q);
      req_valid_s    = reset_n && !redirect_valid && !halted_q
                       && (inflight_q < OW'(MAX_OUTST)) && (used_s < 32'(DEPTH));
      req_fire_s     = req_valid_s && imem_req_ready;
      push_s         = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
      pop_s          = out_valid_q && out_ready && !redirect_valid;
      push_instr_s   = imem_rsp_err ? NOP : imem_rsp_data;
      redirect_tgt_s = redirect_pc & ~XLEN'(3);
   end

   // Next-state for fetch/response PCs, counters and queue pointers; redirect wins.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      halted_d   = halted_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      inflight_d = inflight_q + OW'(req_fire_s) - OW'(imem_rsp_valid);
      if (redirect_valid) begin
         fetch_pc_d = redirect_tgt_s;
         rsp_pc_d   = redirect_tgt_s;
         halted_d   = 1'b0;
         // every response still outstanding after this cycle belongs to the old path
         drop_d     = inflight_q - OW'(imem_rsp_valid);
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (req_fire_s) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - OW'(1);
         end else begin
            drop_d = drop_q;
         end
         if (push_s) begin
            rsp_pc_d = rsp_pc_q + XLEN'(4);
            wr_ptr_d = wr_ptr_q + PW'(1);
            halted_d = halted_q | imem_rsp_err;
         end else begin
            rsp_pc_d = rsp_pc_q;
            wr_ptr_d = wr_ptr_q;
            halted_d = halted_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CW'(push_s) - CW'(pop_s);
      end
   end

   // Next head: the entry at the new read pointer, taken from the incoming push
   // when that push lands exactly at the head (it is not in storage yet).
   always_comb begin
      if (count_d == '0) begin
         out_valid_d = 1'b0;
         out_instr_d = NOP;
         out_pc_d    = '0;
         out_fault_d = 1'b0;
      end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
         out_valid_d = 1'b1;
         out_instr_d = push_instr_s;
         out_pc_d    = rsp_pc_q;
         out_fault_d = imem_rsp_err;
      end else begin
         out_valid_d = 1'b1;
         out_instr_d = instr_mem_q[rd_ptr_d];
         out_pc_d    = pc_mem_q[rd_ptr_d];
         out_fault_d = fault_mem_q[rd_ptr_d];
      end
   end

   // Control state and registered head outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q  <= RESET_VECTOR;
         rsp_pc_q    <= RESET_VECTOR;
         inflight_q  <= '0;
         drop_q      <= '0;
         halted_q    <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_instr_q <= NOP;
         out_pc_q    <= '0;
         out_fault_q <= 1'b0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         rsp_pc_q    <= rsp_pc_d;
         inflight_q  <= inflight_d;
         drop_q      <= drop_d;
         halted_q    <= halted_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         out_fault_q <= out_fault_d;
      end
   end

   // Queue storage write on accepted (non-discarded) response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= NOP;
            fault_mem_q[i] <= 1'b0;
         end
      end else if (push_s) begin
         pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
         instr_mem_q[wr_ptr_q] <= push_instr_s;
         fault_mem_q[wr_ptr_q] <= imem_rsp_err;
      end
   end

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = fetch_pc_q;
   assign out_valid      = out_valid_q;
   assign out_instr      = out_instr_q;
   assign out_pc         = out_pc_q;
   assign out_fault      = out_fault_q;

endmodule
